// File: rtl/apb_slave_regbank_pkg.sv
// Shared types and helpers for the APB slave register bank.
// Purely combinational content: no latency and no backpressure of its own.
package apb_pkg;

    localparam int APB_MAX_DATA_W = 64;
    localparam int APB_MAX_STRB_W = APB_MAX_DATA_W / 8;
    localparam int APB_MAX_REGS   = 256;
    localparam int APB_MAX_WAIT   = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_RO    = 2'd3
    } apb_err_e;

    function automatic logic [APB_MAX_DATA_W-1:0] byte_merge(
        input logic [APB_MAX_DATA_W-1:0] old_dat,
        input logic [APB_MAX_DATA_W-1:0] new_dat,
        input logic [APB_MAX_STRB_W-1:0] strb
    );
        logic [APB_MAX_DATA_W-1:0] res;
        res = old_dat;
        for (int b = 0; b < APB_MAX_STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_dat[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between interconnect and register bank; PSTRB exists only with APB_SLV_PSTRB_EN.
// Wires only: no latency; PREADY is the slave's sole backpressure signal.
interface apb_slave_ifc #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_SLV_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport APB_SLV (
`ifdef APB_SLV_PSTRB_EN
        input  PSTRB,
`endif
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport APB_MST (
`ifdef APB_SLV_PSTRB_EN
        output PSTRB,
`endif
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regbank_regfile.sv
// Register storage with byte-lane merge, read-only protection and flat regs_o export.
// Write lands one cycle after we; read port is combinational; never stalls.
module apb_slv_regfile
    import apb_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter int                     NUM_REGS   = 16,
    parameter int                     IDX_W      = 4,
    parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_dat,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_dat,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
    logic                  wr_in_range;
    logic                  rd_in_range;

    assign wr_in_range = {1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS);
    assign rd_in_range = {1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS);

    always_comb begin
        mem_d = mem_q;
        if (we && wr_in_range && !RO_MASK[wr_idx]) begin
            mem_d[wr_idx] = DATA_WIDTH'(byte_merge(APB_MAX_DATA_W'(mem_q[wr_idx]),
                                                   APB_MAX_DATA_W'(wr_dat),
                                                   APB_MAX_STRB_W'(wr_strb)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read-only entries are never written, but return RESET_VAL explicitly so the intent is local.
    always_comb begin
        rd_dat = '0;
        if (rd_in_range) begin
            rd_dat = RO_MASK[rd_idx] ? RESET_VAL : mem_q[rd_idx];
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave register bank: FSM, wait-state counter and decode; PSTRB lanes with APB_SLV_PSTRB_EN.
// Latency 2+WAIT_STATES cycles per transfer; backpressure is PREADY held low during wait states.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = 12,
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     NUM_REGS    = 16,
    parameter int                     WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0]  RESET_VAL   = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    apb_slave_ifc.APB_SLV                  apb,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_WAIT   = WAIT;
    localparam logic [1:0] ST_ACCESS = ACCESS;

    logic [1:0]            state_q,   state_d;
    logic [3:0]            cnt_q,     cnt_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic                  wr_q,      wr_d;
    logic [DATA_WIDTH-1:0] wdat_q,    wdat_d;
    logic [STRB_W-1:0]     strb_q,    strb_d;
    apb_err_e              err_q,     err_d;
    logic [DATA_WIDTH-1:0] rdat_q,    rdat_d;
    logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
    logic                  pready_q,  pready_d;
    logic                  pslverr_q, pslverr_d;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]      idx;
    logic                  align_bad, range_bad, ro_bad, strb_bad;
    logic [STRB_W-1:0]     strb_in;
    apb_err_e              err_now;
    logic [DATA_WIDTH-1:0] rd_dat, rd_now;
    logic                  commit;

    always_comb begin
        word_addr = apb.PADDR >> OFF_W;
        idx       = word_addr[IDX_W-1:0];
        align_bad = |(apb.PADDR & ADDR_WIDTH'(STRB_W - 1));
        range_bad = ((word_addr >> IDX_W) != '0) || ({1'b0, idx} >= (IDX_W+1)'(NUM_REGS));
        ro_bad    = apb.PWRITE && !range_bad && RO_MASK[idx];
`ifdef APB_SLV_PSTRB_EN
        strb_in   = apb.PSTRB;
        strb_bad  = !apb.PWRITE && (|apb.PSTRB);
`else
        strb_in   = '1;
        strb_bad  = 1'b0;
`endif
        // A strobed read is reported as a lane-alignment fault.
        if (align_bad || strb_bad) begin
            err_now = ERR_ALIGN;
        end else if (range_bad) begin
            err_now = ERR_RANGE;
        end else if (ro_bad) begin
            err_now = ERR_RO;
        end else begin
            err_now = ERR_NONE;
        end
        rd_now = (err_now == ERR_NONE && !apb.PWRITE) ? rd_dat : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdat_d  = wdat_q;
        strb_d  = strb_q;
        err_d   = err_q;
        rdat_d  = rdat_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    idx_d  = idx;
                    wr_d   = apb.PWRITE;
                    wdat_d = apb.PWDATA;
                    strb_d = strb_in;
                    err_d  = err_now;
                    rdat_d = rd_now;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (apb.PENABLE) begin
                    commit  = wr_q && (err_q == ERR_NONE);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Response flops follow the next state so nothing combinational reaches the bus.
        pready_d  = (state_d == ST_ACCESS);
        pslverr_d = (state_d == ST_ACCESS) && (err_d != ERR_NONE);
        prdata_d  = (state_d == ST_ACCESS) ? rdat_d : '0;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            wdat_q    <= '0;
            strb_q    <= '0;
            err_q     <= ERR_NONE;
            rdat_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            wdat_q    <= wdat_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;

    apb_slv_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W),
        .RO_MASK    (RO_MASK),
        .RESET_VAL  (RESET_VAL)
    ) u_regfile (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .we      (commit),
        .wr_idx  (idx_q),
        .wr_dat  (wdat_q),
        .wr_strb (strb_q),
        .rd_idx  (idx),
        .rd_dat  (rd_dat),
        .regs_o  (regs_o)
    );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: u0 uses default parameters, u1 has 3 wait states, register 0 read-only, non-zero reset value.
module tb_apb_slave_regbank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst1_n;
    logic [511:0] regs0, regs1;
    logic [511:0] exp0, exp1;

    apb_slave_ifc #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) if0 ();
    apb_slave_ifc #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) if1 ();

    apb_slave_regbank #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0),
        .RO_MASK(16'h0000), .RESET_VAL(32'h0000_0000)
    ) u0 (
        .PCLK(clk), .PRESETn(rst0_n), .apb(if0), .regs_o(regs0)
    );

    apb_slave_regbank #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(3),
        .RO_MASK(16'h0001), .RESET_VAL(32'h5A5A_0000)
    ) u1 (
        .PCLK(clk), .PRESETn(rst1_n), .apb(if1), .regs_o(regs1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int d, input logic sel, input logic en, input logic wr,
                       input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st);
        if (d == 0) begin
            if0.PSEL = sel; if0.PENABLE = en; if0.PWRITE = wr; if0.PADDR = a; if0.PWDATA = wd;
`ifdef APB_SLV_PSTRB_EN
            if0.PSTRB = st;
`endif
        end else begin
            if1.PSEL = sel; if1.PENABLE = en; if1.PWRITE = wr; if1.PADDR = a; if1.PWDATA = wd;
`ifdef APB_SLV_PSTRB_EN
            if1.PSTRB = st;
`endif
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? if0.PREADY : if1.PREADY;
    endfunction

    function automatic logic serr(input int d);
        return (d == 0) ? if0.PSLVERR : if1.PSLVERR;
    endfunction

    function automatic logic [31:0] prd(input int d);
        return (d == 0) ? if0.PRDATA : if1.PRDATA;
    endfunction

    // Returns at the negedge before the completing edge; PSEL/PENABLE stay high so a
    // following call issues its setup phase back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rdat, output logic err,
                        output int cyc);
        int n;
        @(negedge clk);
        drv(d, 1'b1, 1'b0, wr, a, wd, st);
        cyc = 1;
        @(negedge clk);
        drv(d, 1'b1, 1'b1, wr, a, wd, st);
        n = 0;
        while (rdy(d) !== 1'b1 && n < 20) begin
            cyc++;
            n++;
            @(negedge clk);
        end
        total++;
        assert (n < 20) else begin
            bad++;
            $error("FAIL xfer_timeout: waited %0d cycles, limit 20", n);
        end
        cyc++;
        rdat = prd(d);
        err  = serr(d);
    endtask

    task automatic bus_idle(input int d);
        @(negedge clk);
        drv(d, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc;

    initial begin
        drv(0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        exp0 = '0;
        exp1 = {16{32'h5A5A_0000}};
        repeat (3) @(negedge clk);

        chk("rst_u0_pready",  512'(rdy(0)),  512'(0));
        chk("rst_u0_pslverr", 512'(serr(0)), 512'(0));
        chk("rst_u0_prdata",  512'(prd(0)),  512'(0));
        chk("rst_u0_regs",    regs0, exp0);
        chk("rst_u1_pready",  512'(rdy(1)),  512'(0));
        chk("rst_u1_regs",    regs1, exp1);

        rst0_n = 1'b1;
        rst1_n = 1'b1;

        // Zero-wait write then read
        xfer(0, 1'b1, 12'h004, 32'hDEAD_BEEF, 4'hF, rd, er, cyc);
        chk("wr004_cyc", 512'(cyc), 512'(2));
        chk("wr004_err", 512'(er), 512'(0));
        bus_idle(0);
        exp0[32 +: 32] = 32'hDEAD_BEEF;
        chk("wr004_regs", regs0, exp0);
        chk("wr004_pready_drop", 512'(rdy(0)), 512'(0));

        xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, rd, er, cyc);
        chk("rd004_data", 512'(rd), 512'(32'hDEAD_BEEF));
        chk("rd004_err",  512'(er), 512'(0));
        chk("rd004_cyc",  512'(cyc), 512'(2));

        // Back-to-back write then read of the same word
        xfer(0, 1'b1, 12'h008, 32'h0000_00A5, 4'hF, rd, er, cyc);
        xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, rd, er, cyc);
        chk("b2b_rd_data", 512'(rd), 512'(32'h0000_00A5));
        chk("b2b_rd_cyc",  512'(cyc), 512'(2));
        bus_idle(0);
        exp0[64 +: 32] = 32'h0000_00A5;

        // PSEL+PENABLE from IDLE without setup is ignored
        @(negedge clk);
        drv(0, 1'b1, 1'b1, 1'b1, 12'h00C, 32'h1111_1111, 4'hF);
        repeat (2) @(negedge clk);
        chk("violation_pready", 512'(rdy(0)), 512'(0));
        bus_idle(0);
        chk("violation_regs", regs0, exp0);

        // Misaligned and out-of-range writes
        xfer(0, 1'b1, 12'h002, 32'hBAD0_0001, 4'hF, rd, er, cyc);
        chk("misalign_err", 512'(er), 512'(1));
        chk("misalign_rd",  512'(rd), 512'(0));
        bus_idle(0);
        xfer(0, 1'b1, 12'h040, 32'hBAD0_0002, 4'hF, rd, er, cyc);
        chk("range_wr_err", 512'(er), 512'(1));
        bus_idle(0);
        chk("err_regs_unchanged", regs0, exp0);

        // Last valid index, then first invalid on a read
        xfer(0, 1'b0, 12'h03C, 32'h0, 4'h0, rd, er, cyc);
        chk("rd03c_err",  512'(er), 512'(0));
        chk("rd03c_data", 512'(rd), 512'(0));
        xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, rd, er, cyc);
        chk("rd040_err",  512'(er), 512'(1));
        chk("rd040_data", 512'(rd), 512'(0));
        bus_idle(0);

`ifdef APB_SLV_PSTRB_EN
        xfer(0, 1'b1, 12'h010, 32'h1122_3344, 4'hF, rd, er, cyc);
        xfer(0, 1'b1, 12'h010, 32'hAABB_CCDD, 4'b0101, rd, er, cyc);
        chk("strb_wr_err", 512'(er), 512'(0));
        xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, cyc);
        chk("strb_merge", 512'(rd), 512'(32'h11BB_33DD));
        xfer(0, 1'b1, 12'h010, 32'hFFFF_FFFF, 4'h0, rd, er, cyc);
        chk("strb_zero_err", 512'(er), 512'(0));
        xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, cyc);
        chk("strb_zero_noop", 512'(rd), 512'(32'h11BB_33DD));
        xfer(0, 1'b0, 12'h010, 32'h0, 4'h1, rd, er, cyc);
        chk("strb_on_read_err", 512'(er), 512'(1));
        bus_idle(0);
`endif

        // Three wait states; register 0 is read-only
        xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, rd, er, cyc);
        chk("ws3_rd_cyc",  512'(cyc), 512'(5));
        chk("ws3_rd_data", 512'(rd), 512'(32'h5A5A_0000));
        chk("ws3_rd_err",  512'(er), 512'(0));

        xfer(1, 1'b1, 12'h000, 32'h1234_5678, 4'hF, rd, er, cyc);
        chk("ro_wr_err", 512'(er), 512'(1));
        chk("ro_wr_cyc", 512'(cyc), 512'(5));
        xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, rd, er, cyc);
        chk("ro_rd_data", 512'(rd), 512'(32'h5A5A_0000));
        bus_idle(1);
        chk("ro_regs", regs1, exp1);

        xfer(1, 1'b1, 12'h004, 32'h0102_0304, 4'hF, rd, er, cyc);
        chk("ws3_wr_err", 512'(er), 512'(0));
        xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, rd, er, cyc);
        chk("ws3_rd004", 512'(rd), 512'(32'h0102_0304));
        bus_idle(1);
        exp1[32 +: 32] = 32'h0102_0304;
        chk("ws3_regs", regs1, exp1);

        // Abort: PSEL drops during WAIT
        @(negedge clk);
        drv(1, 1'b1, 1'b0, 1'b1, 12'h008, 32'hFFFF_0000, 4'hF);
        @(negedge clk);
        drv(1, 1'b1, 1'b1, 1'b1, 12'h008, 32'hFFFF_0000, 4'hF);
        @(negedge clk);
        drv(1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        @(negedge clk);
        chk("abort_pready", 512'(rdy(1)), 512'(0));
        chk("abort_regs",   regs1, exp1);
        xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, rd, er, cyc);
        chk("abort_rd008", 512'(rd), 512'(32'h5A5A_0000));
        chk("abort_rd_cyc", 512'(cyc), 512'(5));
        bus_idle(1);

        // Reset during the WAIT phase of a write
        @(negedge clk);
        drv(1, 1'b1, 1'b0, 1'b1, 12'h00C, 32'hCCCC_CCCC, 4'hF);
        @(negedge clk);
        drv(1, 1'b1, 1'b1, 1'b1, 12'h00C, 32'hCCCC_CCCC, 4'hF);
        rst1_n = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        drv(1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        exp1 = {16{32'h5A5A_0000}};
        chk("midrst_pready",  512'(rdy(1)),  512'(0));
        chk("midrst_pslverr", 512'(serr(1)), 512'(0));
        chk("midrst_prdata",  512'(prd(1)),  512'(0));
        chk("midrst_regs",    regs1, exp1);
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, rd, er, cyc);
        chk("midrst_rd00c", 512'(rd), 512'(32'h5A5A_0000));
        bus_idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
# apb_slave_regbank

Parametrised APB slave register bank, successor to the fixed `apb_slave`. It adds configurable data width, register count, inserted wait states, per-register read-only protection and `PSLVERR` error signalling. It sits behind the APB interconnect on the `APB_SLV` side of `apb_slave_ifc` and exposes all register contents as a flat bus for downstream logic.

## Interface
Reset is synchronous and active-low, clocked by `PCLK`.

Parameters:
- `ADDR_WIDTH`, 12: `PADDR` width.
- `DATA_WIDTH`, 32: `PWDATA`/`PRDATA` width. Legal values are 8, 16, 32, 64.
- `NUM_REGS`, 16: number of registers, 1..256.
- `WAIT_STATES`, 0: `PREADY`-low cycles inserted in every access phase, 0..15.
- `RO_MASK`, `'0`: `NUM_REGS` bits; bit i=1 makes register i read-only.
- `RESET_VAL`, `'0`: `DATA_WIDTH` reset value of every register.

Ports:
- `PCLK` in, 1: clock.
- `PRESETn` in, 1: synchronous active-low reset.
- `PSEL` in, 1: slave select.
- `PENABLE` in, 1: access phase.
- `PWRITE` in, 1: 1 = write.
- `PADDR` in, `ADDR_WIDTH`: byte address.
- `PWDATA` in, `DATA_WIDTH`: write data.
- `PSTRB` in, `DATA_WIDTH/8`: byte strobes. Present only with `APB_SLV_PSTRB_EN`.
- `PRDATA` out, `DATA_WIDTH`: read data, registered.
- `PREADY` out, 1: transfer complete, registered.
- `PSLVERR` out, 1: error, valid only while `PREADY`=1.
- `regs_o` out, `NUM_REGS*DATA_WIDTH`: register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- FSM states: `IDLE`, `WAIT`, `ACCESS`.
- `IDLE`
  - On `PSEL`=1 and `PENABLE`=0, latch `PADDR`, `PWRITE`, `PWDATA` (and `PSTRB`) and evaluate the error condition.
  - Go to `WAIT` with counter=`WAIT_STATES` if `WAIT_STATES`>0, otherwise go to `ACCESS`.
- `WAIT`
  - Counter decrements each cycle; on reaching 1, go to `ACCESS`.
  - `PREADY`=0 throughout.
- `ACCESS`
  - `PREADY`=1. `PRDATA` holds read data for reads and 0 for writes and errors. `PSLVERR` holds the latched error.
  - At the edge where `PSEL`&`PENABLE`=1, commit the write if it is error-free, then go to `IDLE`. `PREADY` drops the next cycle.
- Address decode: word index = `PADDR >> log2(DATA_WIDTH/8)`.
- Error condition is any of:
  - non-zero low byte-offset bits;
  - index ≥ `NUM_REGS`;
  - write to an index with `RO_MASK` bit set.
- Error response: no register changes, `PRDATA`=0, `PSLVERR`=1.
- Read-only registers return `RESET_VAL` on read.
- Abort: `PSEL`=0 while in `WAIT` or `ACCESS` returns the FSM to `IDLE` next cycle with no commit and outputs cleared.
- `PSEL`=1 with `PENABLE`=1 while in `IDLE` (protocol violation) is ignored and the FSM stays in `IDLE`.
- Back-to-back: a setup phase in the cycle after completion is accepted from `IDLE` with no extra bubble.

## Timing
- Reset (`PRESETn`=0 at a `PCLK` edge) gives: state `IDLE`, `PREADY`=0, `PSLVERR`=0, `PRDATA`=0, all registers=`RESET_VAL`.
- Reset mid-transfer abandons the transfer with no commit.
- A transfer takes 2+`WAIT_STATES` cycles: 1 setup, `WAIT_STATES` with `PREADY`=0, 1 with `PREADY`=1.
- A write is visible on `regs_o` one cycle after the completing edge.
- A read reflects register contents at the setup edge.
- `PRDATA`, `PREADY` and `PSLVERR` are driven only from flops; no combinational path from inputs.

## Configuration
- Macro: `APB_SLV_PSTRB_EN`.
- Defined:
  - `PSTRB` port exists.
  - A write updates only byte lanes with strobe=1.
  - `PSTRB`=0 is a legal no-op write with `PSLVERR`=0.
  - A non-zero `PSTRB` on a read gives `PSLVERR`=1.
- Undefined: no `PSTRB` port, and every write updates the full word.

## Structure
- Package `apb_pkg` holds:
  - `apb_state_e` (`IDLE`/`WAIT`/`ACCESS`);
  - `apb_err_e` (`ERR_NONE`, `ERR_ALIGN`, `ERR_RANGE`, `ERR_RO`);
  - max-parameter constants;
  - a `byte_merge` function.
- Sub-module `apb_slv_regfile` holds the storage array, strobe merge, `RO_MASK` and the `regs_o` flattening.
- The top holds the FSM, wait counter and decode.

## Test plan
- Defaults (`WAIT_STATES`=0): write 0xDEADBEEF to 0x004, then read 0x004 → `PRDATA`=0xDEADBEEF, `PSLVERR`=0, each transfer 2 cycles.
- `WAIT_STATES`=3: read 0x000 → `PREADY` low for 3 access cycles then high; transfer is 5 cycles.
- Write to 0x002 (misaligned), then to 0x040 (index 16, out of range) → `PSLVERR`=1 with `PREADY` both times, `regs_o` unchanged.
- `RO_MASK`=0x1: write 0x12345678 to 0x000 → `PSLVERR`=1; a read then returns `RESET_VAL`.
- With `APB_SLV_PSTRB_EN`: register=0x11223344, write 0xAABBCCDD with `PSTRB`=4'b0101 → register reads 0x11BB33DD.
- Drop `PRESETn` during the `WAIT` cycle of a write → no commit, all outputs 0; the next read returns the prior value.
